neuron_output_mac: RTL and testbench

- Output-layer neuron, directly downstream of the hidden-layer neurons.
- Consumes hidden-neuron activations serially as signed Q8.12 values (20-bit: sign, 7 integer bits, 12 fraction bits), one (activation, weight) pair per beat.
- Accumulates the weighted sum with a single multiply-accumulate, adds a bias, then saturates and optionally applies ReLU.
- Presents one 20-bit result per N_IN input beats on a valid/ready output.

---
 rtl/neuron_output_mac_if.sv | 21 ++
 rtl/neuron_output_mac.sv | 104 ++++++++++
 tb/tb_neuron_output_mac.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/neuron_output_mac_if.sv
// Stream bundle for the output-layer neuron: activation/weight pairs in,
// one saturated Q8.12 result out, each with its own valid/ready handshake.
interface neuron_output_mac_if;
    logic        in_valid;
    logic        in_ready;
    logic [19:0] in_data;
    logic [19:0] in_weight;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] out_data;

    modport master (
        output in_valid, in_data, in_weight, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_weight, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/neuron_output_mac.sv
// Output-layer neuron: serial multiply-accumulate over N_IN Q8.12 pairs,
// bias add, saturation to 20 bits and optional ReLU on a valid/ready output.
module neuron_output_mac #(
    parameter int                 N_IN = 2,
    parameter logic signed [19:0] BIAS = 20'sh00000,
    parameter bit                 RELU = 1'b1,
    parameter int                 FRAC = 12
) (
    input logic               clk,
    input logic               rst,
    neuron_output_mac_if.slave bus
);

    localparam int ACC_W = 40 + $clog2(N_IN);
    localparam int CNT_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int R_W   = ACC_W - FRAC + 1;  // one spare bit so the bias add cannot wrap

    localparam logic signed [R_W-1:0] SAT_MAX = R_W'(524287);
    localparam logic signed [R_W-1:0] SAT_MIN = R_W'(-524288);
    localparam logic [CNT_W-1:0]      LAST    = CNT_W'(N_IN - 1);

    typedef enum logic [1:0] {ACC, FIN, OUT} state_e;

    state_e                  state_q;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic [CNT_W-1:0]        cnt_q;
    logic                    in_ready_q;
    logic                    out_valid_q;
    logic [19:0]             out_data_q;

    logic signed [39:0]      data_ext;
    logic signed [39:0]      weight_ext;
    logic signed [39:0]      prod;
    logic signed [R_W-1:0]   r_full;
    logic signed [19:0]      r_sat;
    logic signed [19:0]      result_d;

    always_comb begin
        data_ext   = 40'(signed'(bus.in_data));
        weight_ext = 40'(signed'(bus.in_weight));
        prod       = data_ext * weight_ext;
        acc_d      = acc_q + ACC_W'(prod);

        // Arithmetic shift floors toward minus infinity; no rounding is wanted.
        r_full = R_W'(acc_q >>> FRAC) + R_W'(BIAS);
        if (r_full > SAT_MAX) begin
            r_sat = 20'sh7FFFF;
        end else if (r_full < SAT_MIN) begin
            r_sat = 20'sh80000;
        end else begin
            r_sat = r_full[19:0];
        end
        result_d = (RELU && r_sat[19]) ? 20'sh00000 : r_sat;
    end

    // NOTE: every state register uses <= so all of them update from the
    // same pre-edge values; a blocking write here would leak into later reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACC;
            acc_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            unique case (state_q)
                ACC: begin
                    if (bus.in_valid && in_ready_q) begin
                        acc_q <= acc_d;
                        if (cnt_q == LAST) begin
                            cnt_q      <= '0;
                            in_ready_q <= 1'b0;
                            state_q    <= FIN;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                FIN: begin
                    out_data_q  <= result_d;
                    out_valid_q <= 1'b1;
                    state_q     <= OUT;
                end
                OUT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        acc_q       <= '0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ACC;
                    end
                end
                default: state_q <= ACC;
            endcase
        end
    end

    // out_data deliberately holds its value after the handshake.
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_neuron_output_mac.sv
// Bench for neuron_output_mac: two instances (ReLU/no-bias and pass-through/bias)
// share one stimulus stream and are compared each cycle against a reference model.
module tb_neuron_output_mac;

    localparam int      N_IN  = 2;
    localparam longint  BIAS0 = 0;
    localparam longint  BIAS1 = 2048;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [19:0] in_data;
    logic [19:0] in_weight;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    neuron_output_mac_if bus0 ();
    neuron_output_mac_if bus1 ();

    assign bus0.in_valid  = in_valid;
    assign bus0.in_data   = in_data;
    assign bus0.in_weight = in_weight;
    assign bus0.out_ready = out_ready;
    assign bus1.in_valid  = in_valid;
    assign bus1.in_data   = in_data;
    assign bus1.in_weight = in_weight;
    assign bus1.out_ready = out_ready;

    neuron_output_mac #(.N_IN(N_IN), .BIAS(20'sh00000), .RELU(1'b1), .FRAC(12)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0.slave)
    );
    neuron_output_mac #(.N_IN(N_IN), .BIAS(20'sh00800), .RELU(1'b0), .FRAC(12)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1.slave)
    );

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Result of one sample from the plain sum of exact products.
    function automatic logic [19:0] expect_out(longint sum, longint bias, bit relu);
        longint r;
        r = (sum >>> 12) + bias;
        if (r > 524287)  r = 524287;
        if (r < -524288) r = -524288;
        if (relu && r < 0) r = 0;
        return 20'(r);
    endfunction

    // Reference model: 0 = collecting beats, 1 = computing, 2 = presenting result.
    int          m_phase = 0;
    int          m_cnt   = 0;
    longint      m_sum   = 0;
    logic [19:0] m_res0, m_res1;
    logic [19:0] m_out0 = '0;
    logic [19:0] m_out1 = '0;
    bit          m_live  = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0;
            m_cnt   = 0;
            m_sum   = 0;
            m_out0  = '0;
            m_out1  = '0;
            m_live  = 1'b1;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    m_sum += longint'($signed(in_data)) * longint'($signed(in_weight));
                    m_cnt++;
                    if (m_cnt == N_IN) begin
                        m_res0  = expect_out(m_sum, BIAS0, 1'b1);
                        m_res1  = expect_out(m_sum, BIAS1, 1'b0);
                        m_sum   = 0;
                        m_cnt   = 0;
                        m_phase = 1;
                    end
                end
                1: begin
                    m_out0  = m_res0;
                    m_out1  = m_res1;
                    m_phase = 2;
                end
                default: if (out_ready) m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("in_ready0",  32'(bus0.in_ready),  32'(m_phase == 0));
            check("out_valid0", 32'(bus0.out_valid), 32'(m_phase == 2));
            check("out_data0",  32'(bus0.out_data),  32'(m_out0));
            check("in_ready1",  32'(bus1.in_ready),  32'(m_phase == 0));
            check("out_valid1", 32'(bus1.out_valid), 32'(m_phase == 2));
            check("out_data1",  32'(bus1.out_data),  32'(m_out1));
        end
    end

    task automatic drive(bit v, logic [19:0] d, logic [19:0] w, bit r);
        in_valid  = v;
        in_data   = d;
        in_weight = w;
        out_ready = r;
    endtask

    task automatic beat(logic [19:0] d, logic [19:0] w);
        bit ok = 1'b0;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            drive(1'b1, d, w, 1'b1);
            ok = bus0.in_ready;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL beat_timeout actual=in_ready_low required=in_ready_high");
        end
    endtask

    task automatic idle(int n, bit r);
        repeat (n) begin
            @(negedge clk);
            drive(1'b0, 20'($urandom), 20'($urandom), r);
        end
    endtask

    task automatic wait_out(string name, logic [19:0] lit0, logic [19:0] lit1);
        bit seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            drive(1'b0, 20'($urandom), 20'($urandom), 1'b1);
            seen = bus0.out_valid;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=no_out_valid required=out_valid", name);
        end else begin
            check({name, "_dut0"},   32'(bus0.out_data), 32'(lit0));
            check({name, "_dut1"},   32'(bus1.out_data), 32'(lit1));
            check({name, "_model0"}, 32'(m_out0),        32'(lit0));
            check({name, "_model1"}, 32'(m_out1),        32'(lit1));
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b0);
        repeat (2) @(negedge clk);
        check("reset_in_ready",  32'(bus0.in_ready),  32'd1);
        check("reset_out_valid", 32'(bus0.out_valid), 32'd0);
        check("reset_out_data",  32'(bus1.out_data),  32'd0);
        rst = 1'b0;

        beat(20'h04200, 20'h01000);
        beat(20'h04100, 20'h01000);
        wait_out("basic_sum", 20'h08300, 20'h08B00);

        beat(20'h04200, 20'hFF000);
        beat(20'h04100, 20'hFF000);
        wait_out("negative", 20'h00000, 20'hF8500);

        beat(20'h7F000, 20'h02000);
        beat(20'h7F000, 20'h02000);
        wait_out("sat_pos", 20'h7FFFF, 20'h7FFFF);

        beat(20'h7F000, 20'hFE000);
        beat(20'h7F000, 20'hFE000);
        wait_out("sat_neg", 20'h00000, 20'h80000);

        beat(20'h01000, 20'h01000);
        idle(3, 1'b1);
        beat(20'h01000, 20'h01000);
        wait_out("bubbles", 20'h02000, 20'h02800);

        // Result held under backpressure while new pairs are offered.
        beat(20'h03000, 20'h01000);
        beat(20'h01000, 20'h01000);
        begin
            bit seen = 1'b0;
            for (int t = 0; t < 20 && !seen; t++) begin
                @(negedge clk);
                drive(1'b1, 20'($urandom), 20'($urandom), 1'b0);
                seen = bus0.out_valid;
            end
            check("bp_reached", 32'(seen), 32'd1);
            repeat (3) begin
                @(negedge clk);
                drive(1'b1, 20'($urandom), 20'($urandom), 1'b0);
                check("bp_valid",    32'(bus0.out_valid), 32'd1);
                check("bp_in_ready", 32'(bus0.in_ready),  32'd0);
                check("bp_data",     32'(bus0.out_data),  32'h04000);
            end
        end
        wait_out("backpressure", 20'h04000, 20'h04800);

        beat(20'h7F000, 20'h01000);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        beat(20'h01000, 20'h01000);
        beat(20'h01000, 20'h01000);
        wait_out("reset_mid", 20'h02000, 20'h02800);

        for (int i = 0; i < 3000; i++) begin
            logic [19:0] d, w;
            @(negedge clk);
            if ($urandom_range(0, 1) == 0) begin
                d = 20'($urandom);
                w = 20'($urandom);
            end else begin
                d = 20'($signed($urandom_range(0, 16383)) - 8192);
                w = 20'($signed($urandom_range(0, 16383)) - 8192);
            end
            rst = ($urandom_range(0, 299) == 0);
            drive($urandom_range(0, 9) < 7, d, w, $urandom_range(0, 9) < 6);
        end
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, '0, '0, 1'b1);
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
